// File: rtl/hls_deadlock_pkg.sv
// Purpose: shared types and helpers for the HLS deadlock-reporting blocks.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package hls_deadlock_pkg;

    // Detection FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DETECT = 2'd2,
        ST_DONE   = 2'd3
    } dl_state_e;

    // Index of the lowest set bit of a (zero-extended) monitor vector.
    // An all-zero vector returns 0. Scanning from the top down lets the
    // lowest set bit be the last (winning) assignment.
    function automatic logic [4:0] lowest_set_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hls_deadlock_report_if.sv
// Purpose: one-shot deadlock report channel (valid/ready plus report payload).
// Latency: n/a (wires only).
// Backpressure: producer holds valid and payload until valid & ready.
// Ports: report_valid/report_mask/report_idx/report_cycle from the master,
//        report_ready from the slave.
interface hls_deadlock_report_if #(
    parameter int NUM_MON = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 32
);
    logic               report_valid;
    logic               report_ready;
    logic [NUM_MON-1:0] report_mask;
    logic [IDX_W-1:0]   report_idx;
    logic [CNT_W-1:0]   report_cycle;

    modport master (
        output report_valid,
        output report_mask,
        output report_idx,
        output report_cycle,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_mask,
        input  report_idx,
        input  report_cycle,
        output report_ready
    );
endinterface

// File: rtl/hls_deadlock_prio_enc.sv
// Purpose: combinational lowest-set-bit encoder over the monitor block vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: req_i (NUM_MON request bits) -> idx_o (IDX_W index, 0 when none set).
module hls_deadlock_prio_enc
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic [NUM_MON-1:0] req_i,
    output logic [IDX_W-1:0]   idx_o
);

    logic [31:0] req_ext;

    always_comb begin
        req_ext = 32'(req_i);
        idx_o   = IDX_W'(lowest_set_idx(req_ext));
    end

endmodule

// File: rtl/hls_deadlock_report.sv
// Purpose: turns persistent HLS monitor stalls into a sticky deadlock flag + one-shot report.
// Latency: flag/valid rise right after the THRESH-th consecutive blocked edge.
// Backpressure: report held stable until report_valid & report_ready; clear drops it.
// Ports: clock/reset (async active-low), block_in, clear, deadlock, cycle_count,
//        rpt (report channel, master side).
module hls_deadlock_report
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_MON-1:0]    block_in,
    input  logic                  clear,
    output logic                  deadlock,
    output logic [CNT_W-1:0]      cycle_count,
    hls_deadlock_report_if.master rpt
);

    localparam int              PW     = $clog2(THRESH + 1);
    localparam logic [PW-1:0]   THR_M1 = PW'(THRESH - 1);

    dl_state_e          state_q, state_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic               deadlock_q, deadlock_d;
    logic               valid_q, valid_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   rcyc_q, rcyc_d;
    logic [CNT_W-1:0]   cyc_q;

    logic               any_blk;
    logic [IDX_W-1:0]   enc_idx;

    assign any_blk = |block_in;

    // Index is taken from the same block_in sample that gets latched as the mask.
    hls_deadlock_prio_enc #(
        .NUM_MON (NUM_MON),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req_i (block_in),
        .idx_o (enc_idx)
    );

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        deadlock_d = deadlock_q;
        valid_d    = valid_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        rcyc_d     = rcyc_q;

        if (clear) begin
            // clear wins over detection and over an accepting handshake.
            state_d    = ST_IDLE;
            pcnt_d     = '0;
            deadlock_d = 1'b0;
            valid_d    = 1'b0;
            mask_d     = '0;
            idx_d      = '0;
            rcyc_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_blk) begin
                        pcnt_d = PW'(1);
                        if (THRESH == 1) begin
                            state_d    = ST_DETECT;
                            mask_d     = block_in;
                            idx_d      = enc_idx;
                            rcyc_d     = cyc_q;
                            deadlock_d = 1'b1;
                            valid_d    = 1'b1;
                        end else begin
                            state_d = ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    // Only OR-persistence matters; the blocked set may move around.
                    if (!any_blk) begin
                        pcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else if (pcnt_q == THR_M1) begin
                        state_d    = ST_DETECT;
                        mask_d     = block_in;
                        idx_d      = enc_idx;
                        rcyc_d     = cyc_q;
                        deadlock_d = 1'b1;
                        valid_d    = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
                ST_DETECT: begin
                    if (valid_q && rpt.report_ready) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                    end
                end
                ST_DONE: begin
                    // Sticky until clear; block_in is ignored here.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            deadlock_q <= 1'b0;
            valid_q    <= 1'b0;
            mask_q     <= '0;
            idx_q      <= '0;
            rcyc_q     <= '0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            deadlock_q <= deadlock_d;
            valid_q    <= valid_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            rcyc_q     <= rcyc_d;
        end
    end

    // Free-running timestamp; wraps naturally and ignores clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
        end
    end

    assign deadlock         = deadlock_q;
    assign cycle_count      = cyc_q;
    assign rpt.report_valid = valid_q;
    assign rpt.report_mask  = mask_q;
    assign rpt.report_idx   = idx_q;
    assign rpt.report_cycle = rcyc_q;

endmodule

// File: tb/tb_hls_deadlock_report.sv
// Purpose: self-checking bench for hls_deadlock_report (THRESH=8/CNT_W=32 and THRESH=1/CNT_W=4).
// Latency: n/a.
// Backpressure: bench drives report_ready directly.
module tb_hls_deadlock_report;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] block;
    logic       clear;
    logic       ready;

    logic        dl0, dl1;
    logic [31:0] cc0;
    logic [3:0]  cc1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    hls_deadlock_report_if #(.NUM_MON(4), .IDX_W(2), .CNT_W(32)) if0 ();
    hls_deadlock_report_if #(.NUM_MON(4), .IDX_W(2), .CNT_W(4))  if1 ();

    assign if0.report_ready = ready;
    assign if1.report_ready = ready;

    hls_deadlock_report #(.NUM_MON(4), .THRESH(8), .CNT_W(32), .IDX_W(2)) u_dut0 (
        .clock       (clock),
        .reset       (reset),
        .block_in    (block),
        .clear       (clear),
        .deadlock    (dl0),
        .cycle_count (cc0),
        .rpt         (if0.master)
    );

    hls_deadlock_report #(.NUM_MON(4), .THRESH(1), .CNT_W(4), .IDX_W(2)) u_dut1 (
        .clock       (clock),
        .reset       (reset),
        .block_in    (block),
        .clear       (clear),
        .deadlock    (dl1),
        .cycle_count (cc1),
        .rpt         (if1.master)
    );

    // Reference model: run length of consecutive blocked samples and the
    // report a consumer should currently see, for each configuration.
    int         m_thr [2] = '{8, 1};
    longint     m_mod [2] = '{64'h1_0000_0000, 64'd16};
    longint     m_cnt [2];
    longint     m_run [2];
    bit         m_dl  [2];
    bit         m_vld [2];
    logic [3:0] m_mask[2];
    int         m_idx [2];
    longint     m_rc  [2];

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_dl[i] = 0; m_vld[i] = 0;
            m_mask[i] = '0; m_idx[i] = 0; m_rc[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_run[i] = 0; m_dl[i] = 0; m_vld[i] = 0;
                m_mask[i] = '0; m_idx[i] = 0; m_rc[i] = 0;
            end else if (m_vld[i]) begin
                if (ready) m_vld[i] = 0;
            end else if (!m_dl[i]) begin
                if (block != 4'd0) begin
                    m_run[i]++;
                    if (m_run[i] >= m_thr[i]) begin
                        m_dl[i] = 1; m_vld[i] = 1;
                        m_mask[i] = block; m_idx[i] = lowest(block);
                        m_rc[i] = m_cnt[i]; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
        end
    endtask

    task automatic check_all();
        chk("dl0",    64'(dl0),               64'(m_dl[0]));
        chk("vld0",   64'(if0.report_valid),  64'(m_vld[0]));
        chk("mask0",  64'(if0.report_mask),   64'(m_mask[0]));
        chk("idx0",   64'(if0.report_idx),    64'(m_idx[0]));
        chk("rcyc0",  64'(if0.report_cycle),  64'(m_rc[0]));
        chk("cnt0",   64'(cc0),               64'(m_cnt[0]));
        chk("dl1",    64'(dl1),               64'(m_dl[1]));
        chk("vld1",   64'(if1.report_valid),  64'(m_vld[1]));
        chk("mask1",  64'(if1.report_mask),   64'(m_mask[1]));
        chk("idx1",   64'(if1.report_idx),    64'(m_idx[1]));
        chk("rcyc1",  64'(if1.report_cycle),  64'(m_rc[1]));
        chk("cnt1",   64'(cc1),               64'(m_cnt[1]));
    endtask

    // Inputs are set by the caller away from the edge; valid must not follow
    // ready combinationally, so it is compared before the edge too.
    task automatic step();
        #1;
        chk("vld0_pre", 64'(if0.report_valid), 64'(m_vld[0]));
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b0; block = '0; clear = 1'b0; ready = 1'b0;
        model_reset();
        #12 reset = 1'b1;
        #1 check_all();

        // Steady 0100 from edge 10: detection at edge 17, stamped 17.
        steps(10);
        block = 4'b0100;
        steps(7);
        chk("tp1_early", 64'(dl0), 64'd0);
        step();
        chk("tp1_dl",   64'(dl0),              64'd1);
        chk("tp1_mask", 64'(if0.report_mask),  64'h4);
        chk("tp1_idx",  64'(if0.report_idx),   64'd2);
        chk("tp1_cyc",  64'(if0.report_cycle), 64'd17);

        // Backpressure: report held for 5 cycles, then accepted.
        steps(5);
        chk("hold_vld", 64'(if0.report_valid), 64'd1);
        ready = 1'b1;
        step();
        chk("acc_vld", 64'(if0.report_valid), 64'd0);
        chk("acc_dl",  64'(dl0),              64'd1);
        ready = 1'b0; block = '0;
        clear = 1'b1; step(); clear = 1'b0;

        // 7 high, 1 low, 8 high: only the second burst detects.
        block = 4'b0011; steps(7);
        block = 4'b0000; step();
        chk("burst1_dl", 64'(dl0), 64'd0);
        block = 4'b1111; steps(7);
        chk("burst2_early", 64'(dl0), 64'd0);
        step();
        chk("burst2_dl", 64'(dl0), 64'd1);
        ready = 1'b1; step(); ready = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;

        // Rotating blocked set with OR held high.
        block = 4'b0001; steps(3);
        block = 4'b0010; steps(3);
        block = 4'b1000; steps(2);
        chk("rot_dl",   64'(dl0),             64'd1);
        chk("rot_mask", 64'(if0.report_mask), 64'h8);
        chk("rot_idx",  64'(if0.report_idx),  64'd3);

        // clear and ready together in DETECT: report dropped, not accepted.
        clear = 1'b1; ready = 1'b1; step();
        chk("clr_dl",  64'(dl0),              64'd0);
        chk("clr_vld", 64'(if0.report_valid), 64'd0);
        clear = 1'b0; ready = 1'b0;
        block = 4'b0010; steps(7);
        chk("redet_early", 64'(dl0), 64'd0);
        step();
        chk("redet_dl",  64'(dl0),            64'd1);
        chk("redet_idx", 64'(if0.report_idx), 64'd1);
        ready = 1'b1; step(); ready = 1'b0;
        block = '0; clear = 1'b1; step(); clear = 1'b0;

        // Asynchronous reset while counting clears outputs before any edge.
        block = 4'b0001; steps(3);
        #2 reset = 1'b0;
        #1;
        chk("arst_dl0",  64'(dl0),              64'd0);
        chk("arst_cnt0", 64'(cc0),              64'd0);
        chk("arst_vld1", 64'(if1.report_valid), 64'd0);
        chk("arst_dl1",  64'(dl1),              64'd0);
        chk("arst_rc1",  64'(if1.report_cycle), 64'd0);
        chk("arst_cnt1", 64'(cc1),              64'd0);
        model_reset();
        #2 reset = 1'b1;
        block = '0;
        steps(20);
        // THRESH=1 detects on the very first blocked sample; 4-bit stamp wraps.
        block = 4'b0100; step();
        chk("wrap_dl1",  64'(dl1),              64'd1);
        chk("wrap_rc1",  64'(if1.report_cycle), 64'd4);
        block = '0; clear = 1'b1; step(); clear = 1'b0;

        // Randomized traffic, biased toward long blocked runs.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 8) block = 4'($urandom_range(1, 15));
            else                          block = 4'd0;
            clear = ($urandom_range(0, 39) == 0);
            ready = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
